// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder memory-side slave.
package mem_resp_pkg;
  localparam int DWORD_W  = 64;
  localparam int PADDR_W  = 56;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/mem_resp_sram.sv
// Doubleword backing store: one synchronous write port, one combinational read port.
module mem_resp_sram
  import mem_resp_pkg::*;
#(
  parameter int WORDS = 4096,
  parameter int IDX_W = 12
) (
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [DWORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]   raddr,
  output logic [DWORD_W-1:0] rdata
);
  logic [DWORD_W-1:0] mem_r [WORDS];

  // Write port; contents are intentionally never reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];
endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one read/write at a time, optionally stalls for
// WAIT_STATES cycles (only when MEM_RESP_WAIT_EN is defined), answers in RESP.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int                 MEM_WORDS   = 4096,
  parameter logic [PADDR_W-1:0] BASE_ADDR   = 56'h0,
  parameter int                 WAIT_STATES = 2
) (
  input  logic               phi2,
  input  logic               rst,
  input  logic               read_rq,
  input  logic               write_rq,
  input  logic [PADDR_W-1:0] addr,
  input  logic [DWORD_W-1:0] wdata,
  output logic [DWORD_W-1:0] rdata,
  output logic               busy,
  output logic               fault
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  // Upper bound kept one bit wider so BASE_ADDR near the top cannot wrap
  localparam logic [PADDR_W:0] LIMIT_ADDR =
      {1'b0, BASE_ADDR} + ((PADDR_W+1)'(MEM_WORDS) << 3);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [PADDR_W-1:0]   addr_r;
  logic [DWORD_W-1:0]   wdata_r;
  logic                 rd_r;
  logic                 wr_r;
  logic                 req_s;
  logic [PADDR_W-1:0]   cur_addr_s;
  logic [DWORD_W-1:0]   cur_wdata_s;
  logic                 cur_rd_s;
  logic                 cur_wr_s;
  logic [PADDR_W-1:0]   offset_s;
  logic [IDX_W-1:0]     idx_s;
  logic                 fault_s;
  logic                 enter_resp_s;
  logic                 we_s;
  logic [DWORD_W-1:0]   sram_rdata_s;
  logic [DWORD_W-1:0]   rdata_r;
  logic                 fault_r;

  assign req_s = read_rq | write_rq;

`ifdef MEM_RESP_WAIT_EN
  localparam int WS_EFF = (WAIT_STATES > MAX_WAIT) ? MAX_WAIT : WAIT_STATES;
  localparam bit USE_WAIT = (WS_EFF > 0);
  localparam logic [CNT_W-1:0] CNT_LOAD =
      (WS_EFF > 0) ? CNT_W'(WS_EFF - 1) : {CNT_W{1'b0}};

  logic [CNT_W-1:0] wait_cnt_r;

  // Stall counter: loaded on acceptance, counts down through WAIT
  always_ff @(posedge phi2) begin
    if (rst) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_IDLE && req_s) begin
      wait_cnt_r <= CNT_LOAD;
    end else if (state_r == ST_WAIT && wait_cnt_r != {CNT_W{1'b0}}) begin
      wait_cnt_r <= wait_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end
`endif

  // State register
  always_ff @(posedge phi2) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
`ifdef MEM_RESP_WAIT_EN
          if (USE_WAIT) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_RESP;
          end
`else
          state_nxt_s = ST_RESP;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
`ifdef MEM_RESP_WAIT_EN
      ST_WAIT: begin
        if (wait_cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
`endif
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output logic: stall the initiator from acceptance until RESP
  always_comb begin
    busy = 1'b0;
    if (rst) begin
      busy = 1'b0;
    end else if (state_r == ST_IDLE) begin
      busy = req_s;
    end else if (state_r == ST_WAIT) begin
      busy = 1'b1;
    end else begin
      busy = 1'b0;
    end
  end

  // Request capture on acceptance; later input changes are ignored
  always_ff @(posedge phi2) begin
    if (rst) begin
      addr_r  <= {PADDR_W{1'b0}};
      wdata_r <= {DWORD_W{1'b0}};
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
    end else if (state_r == ST_IDLE && req_s) begin
      addr_r  <= addr;
      wdata_r <= wdata;
      rd_r    <= read_rq;
      wr_r    <= write_rq;
    end else begin
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      rd_r    <= rd_r;
      wr_r    <= wr_r;
    end
  end

  // Live inputs in IDLE so a zero-wait access can complete on its acceptance edge
  always_comb begin
    cur_addr_s  = addr_r;
    cur_wdata_s = wdata_r;
    cur_rd_s    = rd_r;
    cur_wr_s    = wr_r;
    if (state_r == ST_IDLE) begin
      cur_addr_s  = addr;
      cur_wdata_s = wdata;
      cur_rd_s    = read_rq;
      cur_wr_s    = write_rq;
    end else begin
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
      cur_rd_s    = rd_r;
      cur_wr_s    = wr_r;
    end
  end

  // Access check: alignment, window, and conflicting request types
  always_comb begin
    fault_s = 1'b0;
    if (cur_addr_s[2:0] != 3'd0) begin
      fault_s = 1'b1;
    end else if (cur_addr_s < BASE_ADDR) begin
      fault_s = 1'b1;
    end else if ({1'b0, cur_addr_s} >= LIMIT_ADDR) begin
      fault_s = 1'b1;
    end else if (cur_rd_s && cur_wr_s) begin
      fault_s = 1'b1;
    end else begin
      fault_s = 1'b0;
    end
  end

  assign offset_s     = cur_addr_s - BASE_ADDR;
  assign idx_s        = IDX_W'(offset_s >> 3);
  assign enter_resp_s = !rst && (state_nxt_s == ST_RESP);
  assign we_s         = enter_resp_s && cur_wr_s && !fault_s;

  mem_resp_sram #(
    .WORDS (MEM_WORDS),
    .IDX_W (IDX_W)
  ) u_sram (
    .clk   (phi2),
    .we    (we_s),
    .waddr (idx_s),
    .wdata (cur_wdata_s),
    .raddr (idx_s),
    .rdata (sram_rdata_s)
  );

  // Response registers: populated only for the single RESP cycle
  always_ff @(posedge phi2) begin
    if (rst) begin
      rdata_r <= {DWORD_W{1'b0}};
      fault_r <= 1'b0;
    end else if (enter_resp_s) begin
      fault_r <= fault_s;
      rdata_r <= (cur_rd_s && !fault_s) ? sram_rdata_s : {DWORD_W{1'b0}};
    end else begin
      rdata_r <= {DWORD_W{1'b0}};
      fault_r <= 1'b0;
    end
  end

  assign rdata = rdata_r;
  assign fault = fault_r;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table plus reset and back-to-back sequences.
module tb_mem_responder;
  localparam int WS = 2;
`ifdef MEM_RESP_WAIT_EN
  localparam int LAT = WS + 1;
`else
  localparam int LAT = 1;
`endif

  logic        phi2;
  logic        rst;
  logic        read_rq;
  logic        write_rq;
  logic [55:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        busy;
  logic        fault;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [55:0] a;
    logic [63:0] d;
    logic [63:0] er;
    bit          ef;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        fault;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp;
  int   n_fail;

  mem_responder #(
    .MEM_WORDS   (4096),
    .BASE_ADDR   (56'h0),
    .WAIT_STATES (WS)
  ) dut (
    .phi2     (phi2),
    .rst      (rst),
    .read_rq  (read_rq),
    .write_rq (write_rq),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .busy     (busy),
    .fault    (fault)
  );

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input bit rd, input bit wr, input logic [55:0] a,
                     input logic [63:0] d, input logic [63:0] er, input bit ef);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.d = d; v.er = er; v.ef = ef;
    tbl.push_back(v);
  endtask

  // Called 1 time unit after a rising edge; returns sampled inside RESP.
  task automatic access(input bit rd, input bit wr, input logic [55:0] a,
                        input logic [63:0] d, input logic [63:0] er, input bit ef,
                        input bit hold);
    exp_t e;
    exp_t got;
    int   cnt;
    read_rq = rd; write_rq = wr; addr = a; wdata = d;
    e.rdata = er; e.fault = ef;
    sb.push_back(e);
    #1;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(posedge phi2); #1;
      if (!hold) begin
        read_rq = 1'b0; write_rq = 1'b0; addr = ~a; wdata = ~d;
      end
    end
    chk("busy_cycles", 64'(cnt), 64'(LAT));
    got = sb.pop_front();
    chk("resp_rdata", rdata, got.rdata);
    chk("resp_fault", {63'd0, fault}, {63'd0, got.fault});
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; read_rq = 1'b0; write_rq = 1'b0; addr = 56'h0; wdata = 64'h0;

    add(1'b0, 1'b1, 56'h0,    64'hA5A5_0000_0000_5A5A, 64'h0, 1'b0);
    add(1'b0, 1'b1, 56'h8,    64'h8888_7777_6666_5555, 64'h0, 1'b0);
    add(1'b0, 1'b1, 56'h40,   64'hDEAD_BEEF_0123_4567, 64'h0, 1'b0);
    add(1'b1, 1'b0, 56'h40,   64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0);
    add(1'b0, 1'b1, 56'h80,   64'h1122_3344_5566_7788, 64'h0, 1'b0);
    add(1'b1, 1'b0, 56'h80,   64'h0, 64'h1122_3344_5566_7788, 1'b0);
    add(1'b1, 1'b0, 56'h44,   64'h0, 64'h0, 1'b1);
    add(1'b1, 1'b0, 56'h8000, 64'h0, 64'h0, 1'b1);
    add(1'b0, 1'b1, 56'h8000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    add(1'b1, 1'b0, 56'h0,    64'h0, 64'hA5A5_0000_0000_5A5A, 1'b0);
    add(1'b1, 1'b1, 56'h80,   64'h0BAD_0BAD_0BAD_0BAD, 64'h0, 1'b1);
    add(1'b1, 1'b0, 56'h80,   64'h0, 64'h1122_3344_5566_7788, 1'b0);
    add(1'b0, 1'b1, 56'h82,   64'hCAFE_CAFE_CAFE_CAFE, 64'h0, 1'b1);
    add(1'b1, 1'b0, 56'h80,   64'h0, 64'h1122_3344_5566_7788, 1'b0);
    add(1'b0, 1'b1, 56'h7FF8, 64'h0F0F_F0F0_0F0F_F0F0, 64'h0, 1'b0);
    add(1'b1, 1'b0, 56'h7FF8, 64'h0, 64'h0F0F_F0F0_0F0F_F0F0, 1'b0);
    add(1'b0, 1'b1, 56'h100,  64'h0100_0100_0100_0100, 64'h0, 1'b0);

    repeat (2) @(posedge phi2);
    #1;
    chk("reset_busy",  {63'd0, busy},  64'h0);
    chk("reset_rdata", rdata,          64'h0);
    chk("reset_fault", {63'd0, fault}, 64'h0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      access(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].er, tbl[i].ef, 1'b0);
      @(posedge phi2); #1;
      chk("idle_rdata", rdata, 64'h0);
      chk("idle_fault", {63'd0, fault}, 64'h0);
    end

    // Reset during the last stall cycle of a write must drop the write
    write_rq = 1'b1; addr = 56'h100; wdata = 64'hFFFF_0000_FFFF_0000;
    repeat (LAT - 1) begin
      @(posedge phi2); #1;
    end
    rst = 1'b1; write_rq = 1'b0;
    @(posedge phi2); #1;
    rst = 1'b0;
    chk("rst_busy",  {63'd0, busy},  64'h0);
    chk("rst_rdata", rdata,          64'h0);
    chk("rst_fault", {63'd0, fault}, 64'h0);
    access(1'b1, 1'b0, 56'h100, 64'h0, 64'h0100_0100_0100_0100, 1'b0, 1'b0);
    @(posedge phi2); #1;

    // Back-to-back reads with read_rq held high throughout
    access(1'b1, 1'b0, 56'h0, 64'h0, 64'hA5A5_0000_0000_5A5A, 1'b0, 1'b1);
    addr = 56'h8;
    #1;
    chk("b2b_resp_busy", {63'd0, busy}, 64'h0);
    @(posedge phi2); #1;
    access(1'b1, 1'b0, 56'h8, 64'h0, 64'h8888_7777_6666_5555, 1'b0, 1'b1);
    read_rq = 1'b0;
    @(posedge phi2); #1;
    chk("b2b_idle_busy",  {63'd0, busy}, 64'h0);
    chk("b2b_idle_rdata", rdata,         64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096: number of 64-bit doublewords of backing storage (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 56'h0: physical byte address of doubleword 0.
REQ-003 SHALL have parameter WAIT_STATES, default 2: extra stall cycles per access (0..15).
REQ-004 SHALL have port phi2  input  1: clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port read_rq  input  1: initiator read request.
REQ-007 SHALL have port write_rq  input  1: initiator write request.
REQ-008 SHALL have port addr  input  56: physical byte address.
REQ-009 SHALL have port wdata  input  64: write data.
REQ-010 SHALL have port rdata  output  64: read data, valid only in RESP.
REQ-011 SHALL have port busy  output  1: stall to initiator; high while the access is in progress.
REQ-012 SHALL have port fault  output  1: access error, valid only in RESP.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 In IDLE with read_rq or write_rq high, the request SHALL be accepted and addr, wdata and request type latched.
REQ-015 On acceptance, the FSM SHALL go to WAIT if WAIT_STATES>0, else to RESP.
REQ-016 In WAIT, a 4-bit counter loaded with WAIT_STATES-1 SHALL decrement each cycle; at 0 the FSM SHALL go to RESP.
REQ-017 RESP SHALL last exactly one cycle, then return to IDLE.
REQ-018 busy SHALL be combinational: high in IDLE whenever a request is present, high throughout WAIT, low in RESP and in idle IDLE.
REQ-019 Total busy duration per access SHALL be WAIT_STATES+1 cycles, with completion in the following cycle.
REQ-020 Read data SHALL be driven on rdata during RESP and SHALL be 0 in all other states.
REQ-021 A write SHALL be committed to storage on the edge entering RESP, never earlier.
REQ-022 Input changes after acceptance SHALL be ignored; the latched values govern the access.
REQ-023 Dropping read_rq/write_rq during WAIT SHALL NOT abort the access.
REQ-024 A request present in IDLE on the cycle after RESP SHALL be treated as a new access, giving back-to-back operation.
REQ-025 fault SHALL be raised in RESP, with no write and rdata=0, when addr[2:0]!=0.
REQ-026 fault SHALL likewise be raised when addr<BASE_ADDR or addr>=BASE_ADDR+8*MEM_WORDS.
REQ-027 fault SHALL likewise be raised when read_rq and write_rq are both high at acceptance.
REQ-028 Index arithmetic SHALL be (addr-BASE_ADDR)>>3, truncated to log2(MEM_WORDS) bits after the range check.

Reset
REQ-029 On rst, the FSM SHALL go to IDLE, the counter to 0, and busy, fault and rdata to 0.
REQ-030 rst mid-access SHALL abandon the access without committing the write.
REQ-031 Storage contents SHALL NOT be cleared by rst.

Configuration
REQ-032 With MEM_RESP_WAIT_EN defined, WAIT state and counter SHALL exist and WAIT_STATES SHALL apply.
REQ-033 Without MEM_RESP_WAIT_EN, WAIT and the counter SHALL be absent, WAIT_STATES SHALL be ignored, and every access SHALL take IDLE->RESP with 1 busy cycle.

Structure
REQ-034 Package mem_resp_pkg SHALL hold the state enum, DWORD_W=64, PADDR_W=56 and the max-wait constant 15.
REQ-035 Storage SHALL be sub-module mem_resp_sram: one read port and one write port, synchronous write, combinational read.

Verification
REQ-036 WAIT_STATES=2: read_rq at 0x40 (word 8 preloaded 64'hDEAD_BEEF_0123_4567) -> busy high 3 cycles, then RESP with that rdata, fault=0.
REQ-037 write_rq 0x80 with wdata 64'h1122_3344_5566_7788, followed by a read of 0x80 -> read returns 64'h1122_3344_5566_7788.
REQ-038 Read of 0x44 (misaligned) or 0x8000 (MEM_WORDS=4096, out of range) -> fault=1 in RESP, rdata=0; write to 0x8000 leaves storage unchanged.
REQ-039 read_rq and write_rq both high -> fault=1 and no storage change.
REQ-040 rst asserted in the second WAIT cycle of a write to 0x100 -> IDLE next cycle, word 0x100 unchanged, busy=0.
REQ-041 Without MEM_RESP_WAIT_EN: back-to-back reads 0x0, 0x8 -> busy high 1 cycle each, RESP every second cycle.
